except_ctrl: RTL and testbench
==============================

Name: except_ctrl

Overview:
- MEM-stage exception arbiter and pipeline-flush sequencer.
- Sits directly upstream of cp0_reg. It takes per-instruction exception flags from MEM plus CP0 Status/Cause/EPC, forwarding any WB-stage mtc0 over those CP0 values.
- It produces the single encoded excepttype, faulting PC and delay-slot flag that cp0_reg consumes.
- It then drives a registered flush/redirect sequence to ctrl and pc_reg.

Parameters:
- EXC_VECTOR, 32'h00000020, handler entry PC for every exception except eret.
- FLUSH_CYCLES, 1, number of cycles flush_o is held high (legal range 1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- mem_excepttype_i  in  32  raw flags: [8] syscall, [9] invalid inst, [10] trap, [11] overflow, [12] eret.
- mem_pc_i  in  32  PC of the instruction in MEM.
- mem_is_in_delayslot_i  in  1  MEM instruction is in a delay slot.
- status_i  in  32  CP0 Status.
- cause_i  in  32  CP0 Cause.
- epc_i  in  32  CP0 EPC.
- wb_cp0_we_i  in  1  WB-stage mtc0 write enable.
- wb_cp0_waddr_i  in  5  WB-stage mtc0 register address.
- wb_cp0_data_i  in  32  WB-stage mtc0 data.
- excepttype_o  out  32  encoded exception to cp0_reg.
- current_inst_addr_o  out  32  equals mem_pc_i.
- is_in_delayslot_o  out  1  equals mem_is_in_delayslot_i.
- flush_o  out  1  pipeline flush, registered.
- new_pc_o  out  32  redirect PC, valid while flush_o=1.
- busy_o  out  1  FSM is not IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, flush_o=0, new_pc_o=0, busy_o=0, counter=0, and excepttype_o=0 regardless of other inputs.
- Forwarding (combinational):
  - If wb_cp0_we_i=1 and wb_cp0_waddr_i=12, use wb_cp0_data_i as Status.
  - If wb_cp0_we_i=1 and wb_cp0_waddr_i=14, use wb_cp0_data_i as EPC.
  - If wb_cp0_we_i=1 and wb_cp0_waddr_i=13, use Cause with bits [9:8] replaced by wb data [9:8]; all other Cause bits come from cause_i.
- Valid instruction: mem_pc_i != 0. If the instruction is not valid, excepttype_o=0.
- Interrupt pending: ((Cause[15:8] & Status[15:8]) != 0) && Status[1]==0 && Status[0]==1, using forwarded values.
- Encoding, fixed priority, evaluated in IDLE only:
  - interrupt: 32'h1
  - [8] syscall: 32'h8
  - [9] invalid inst: 32'ha
  - [10] trap: 32'hd
  - [11] overflow: 32'hc
  - [12] eret: 32'he
  - none of the above: 0
- excepttype_o is combinational, valid in the same cycle as the MEM inputs, so cp0_reg samples it on the next edge. It is forced to 0 in every state other than IDLE.
- FSM with states IDLE and FLUSH:
  - IDLE -> FLUSH when excepttype_o != 0. On that edge: flush_o<=1, counter<=FLUSH_CYCLES-1, new_pc_o<=forwarded EPC if the code is 32'he, else EXC_VECTOR.
  - In FLUSH, if counter==0: go to IDLE and set flush_o<=0. Otherwise counter decrements.
  - flush_o is high for exactly FLUSH_CYCLES cycles, starting one cycle after detection.
  - new_pc_o holds its value until the next entry to FLUSH; it is not cleared on return to IDLE.
  - busy_o = (state==FLUSH).
- Exceptions arriving in MEM during FLUSH are ignored; the pipeline is being flushed. No queueing.
- A new exception detected in the first IDLE cycle after FLUSH is accepted normally, giving back-to-back sequences.
- Simultaneous flags resolve by priority only. Only one code is emitted per detection.
- If rst asserts mid-FLUSH: return to IDLE immediately and drop flush_o asynchronously.

Decomposition:
- Shared package/defines (extend defines.v):
  - excepttype codes EXC_INT/SYSCALL/INST_INVALID/TRAP/OV/ERET
  - raw-flag bit indices 8..12
  - CP0 address macros already used by cp0_reg (12 Status, 13 Cause, 14 EPC)
- One natural sub-module: cp0_fwd. It is a combinational WB-to-CP0 forwarding mux producing Status/Cause/EPC, and is reusable by the EX-stage mfc0 path.

Test Plan:
- Reset released with mem_pc_i=0x100 and mem_excepttype_i[8]=1: excepttype_o=0x8 that cycle. Next cycle flush_o=1 and new_pc_o=0x20. With FLUSH_CYCLES=1, flush_o=0 one cycle later.
- Status=0x1000_0401, Cause[10]=1, [8] syscall also set: excepttype_o=0x1 (interrupt wins). Repeat with Status[1]=1: excepttype_o=0x8.
- eret flag with epc_i=0x200, WB mtc0 to reg 14 with data 0x300 in the same cycle: new_pc_o=0x300.
- FLUSH_CYCLES=3: flush_o high for exactly 3 cycles. An overflow flag presented during cycle 2 gives excepttype_o=0, and no re-entry to FLUSH.
- Assert rst asynchronously mid-FLUSH: flush_o and busy_o drop before the next clk edge, and excepttype_o=0 while rst=1.
- mem_pc_i=0 with [9] set: excepttype_o=0, no flush. Then mem_pc_i=0x104 with [9] set: excepttype_o=0xa, is_in_delayslot_o tracks its input.

Source files
------------

// File: rtl/except_ctrl_pkg.sv
// Shared definitions for the MEM-stage exception path: excepttype codes,
// raw-flag bit positions, CP0 register addresses and the flush FSM states.
package except_ctrl_pkg;

    localparam logic [31:0] EXC_INT          = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
    localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
    localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
    localparam logic [31:0] EXC_OV           = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

    localparam int FLAG_SYSCALL      = 8;
    localparam int FLAG_INST_INVALID = 9;
    localparam int FLAG_TRAP         = 10;
    localparam int FLAG_OV           = 11;
    localparam int FLAG_ERET         = 12;

    localparam logic [4:0] CP0_REG_STATUS = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_REG_EPC    = 5'd14;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_t;

endpackage

// File: rtl/cp0_fwd.sv
// Combinational WB-to-CP0 forwarding: overlays an in-flight mtc0 onto the
// architectural Status/Cause/EPC so consumers see the newest values.
module cp0_fwd
    import except_ctrl_pkg::*;
(
    input  logic [31:0] status,
    input  logic [31:0] cause,
    input  logic [31:0] epc,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_data,
    output logic [31:0] fwd_status,
    output logic [31:0] fwd_cause,
    output logic [31:0] fwd_epc
);

    // NOTE: every output gets a default before the conditional overrides, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        fwd_status = status;
        fwd_cause  = cause;
        fwd_epc    = epc;
        if (wb_we) begin
            unique case (wb_waddr)
                CP0_REG_STATUS: fwd_status = wb_data;
                // Only the software-interrupt bits of Cause are writable.
                CP0_REG_CAUSE:  fwd_cause  = {cause[31:10], wb_data[9:8], cause[7:0]};
                CP0_REG_EPC:    fwd_epc    = wb_data;
                default:        ;
            endcase
        end
    end

endmodule

// File: rtl/except_ctrl.sv
// MEM-stage exception arbiter: encodes the highest-priority exception for
// cp0_reg and sequences the registered flush/redirect to ctrl and pc_reg.
module except_ctrl
    import except_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_excepttype_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_is_in_delayslot_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    logic [31:0] fwd_status;
    logic [31:0] fwd_cause;
    logic [31:0] fwd_epc;
    logic        int_pending;
    logic        inst_valid;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  counter;
    logic [3:0]  counter_nxt;
    logic        flush_nxt;
    logic [31:0] new_pc_nxt;

    cp0_fwd u_cp0_fwd (
        .status     (status_i),
        .cause      (cause_i),
        .epc        (epc_i),
        .wb_we      (wb_cp0_we_i),
        .wb_waddr   (wb_cp0_waddr_i),
        .wb_data    (wb_cp0_data_i),
        .fwd_status (fwd_status),
        .fwd_cause  (fwd_cause),
        .fwd_epc    (fwd_epc)
    );

    assign current_inst_addr_o = mem_pc_i;
    assign is_in_delayslot_o   = mem_is_in_delayslot_i;
    assign busy_o              = (state == ST_FLUSH);
    assign inst_valid          = (mem_pc_i != 32'd0);
    assign int_pending         = ((fwd_cause[15:8] & fwd_status[15:8]) != 8'd0)
                                 && !fwd_status[1] && fwd_status[0];

    always_comb begin
        excepttype_o = 32'd0;
        if (!rst && state == ST_IDLE && inst_valid) begin
            if (int_pending)                             excepttype_o = EXC_INT;
            else if (mem_excepttype_i[FLAG_SYSCALL])      excepttype_o = EXC_SYSCALL;
            else if (mem_excepttype_i[FLAG_INST_INVALID]) excepttype_o = EXC_INST_INVALID;
            else if (mem_excepttype_i[FLAG_TRAP])         excepttype_o = EXC_TRAP;
            else if (mem_excepttype_i[FLAG_OV])           excepttype_o = EXC_OV;
            else if (mem_excepttype_i[FLAG_ERET])         excepttype_o = EXC_ERET;
        end
    end

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        flush_nxt   = flush_o;
        new_pc_nxt  = new_pc_o;
        case (state)
            ST_IDLE: begin
                if (excepttype_o != 32'd0) begin
                    state_nxt   = ST_FLUSH;
                    flush_nxt   = 1'b1;
                    counter_nxt = FLUSH_LOAD;
                    new_pc_nxt  = (excepttype_o == EXC_ERET) ? fwd_epc : EXC_VECTOR;
                end
            end
            ST_FLUSH: begin
                if (counter == 4'd0) begin
                    state_nxt = ST_IDLE;
                    flush_nxt = 1'b0;
                end else begin
                    counter_nxt = counter - 4'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            counter  <= 4'd0;
            flush_o  <= 1'b0;
            new_pc_o <= 32'd0;
        end else begin
            state    <= state_nxt;
            counter  <= counter_nxt;
            flush_o  <= flush_nxt;
            new_pc_o <= new_pc_nxt;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{mem_excepttype_i[31:13], mem_excepttype_i[7:0],
                         fwd_status[31:16], fwd_status[7:2],
                         fwd_cause[31:16], fwd_cause[7:0]};

endmodule

// File: tb/tb_except_ctrl.sv
// Self-checking bench: two instances (flush length 1 and 3) driven in
// parallel, compared each cycle against a remaining-flush-cycles model.
module tb_except_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] exc_flags;
    logic [31:0] mem_pc;
    logic        mem_ds;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_data;

    logic [31:0] exc1, exc3, cia1, cia3, npc1, npc3;
    logic        ds1, ds3, flush1, flush3, busy1, busy3;

    int n_tests = 0;
    int n_fail  = 0;

    int          rem1, rem3;
    logic [31:0] mpc1, mpc3;

    always #5 clk = ~clk;

    except_ctrl #(.EXC_VECTOR(32'h20), .FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .mem_excepttype_i(exc_flags), .mem_pc_i(mem_pc),
        .mem_is_in_delayslot_i(mem_ds), .status_i(status), .cause_i(cause), .epc_i(epc),
        .wb_cp0_we_i(wb_we), .wb_cp0_waddr_i(wb_waddr), .wb_cp0_data_i(wb_data),
        .excepttype_o(exc1), .current_inst_addr_o(cia1), .is_in_delayslot_o(ds1),
        .flush_o(flush1), .new_pc_o(npc1), .busy_o(busy1)
    );

    except_ctrl #(.EXC_VECTOR(32'h20), .FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .mem_excepttype_i(exc_flags), .mem_pc_i(mem_pc),
        .mem_is_in_delayslot_i(mem_ds), .status_i(status), .cause_i(cause), .epc_i(epc),
        .wb_cp0_we_i(wb_we), .wb_cp0_waddr_i(wb_waddr), .wb_cp0_data_i(wb_data),
        .excepttype_o(exc3), .current_inst_addr_o(cia3), .is_in_delayslot_o(ds3),
        .flush_o(flush3), .new_pc_o(npc3), .busy_o(busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] eff_status();
        return (wb_we && wb_waddr == 5'd12) ? wb_data : status;
    endfunction

    function automatic logic [31:0] eff_cause();
        logic [31:0] c;
        c = cause;
        if (wb_we && wb_waddr == 5'd13) c[9:8] = wb_data[9:8];
        return c;
    endfunction

    function automatic logic [31:0] eff_epc();
        return (wb_we && wb_waddr == 5'd14) ? wb_data : epc;
    endfunction

    // Exception code for the current MEM inputs, assuming the arbiter is idle.
    function automatic logic [31:0] ref_code();
        logic [31:0] s, c;
        s = eff_status();
        c = eff_cause();
        if (mem_pc == 32'd0) return 32'd0;
        if ((c[15:8] & s[15:8]) != 0 && s[1] == 1'b0 && s[0] == 1'b1) return 32'h1;
        if (exc_flags[8])  return 32'h8;
        if (exc_flags[9])  return 32'ha;
        if (exc_flags[10]) return 32'hd;
        if (exc_flags[11]) return 32'hc;
        if (exc_flags[12]) return 32'he;
        return 32'd0;
    endfunction

    task automatic quiet();
        exc_flags = 32'd0; mem_pc = 32'd0; mem_ds = 1'b0;
        status = 32'd0; cause = 32'd0; epc = 32'd0;
        wb_we = 1'b0; wb_waddr = 5'd0; wb_data = 32'd0;
    endtask

    // Check every output against the model mid-cycle, then advance the model
    // across the next rising edge. Returns 1 time unit after that edge.
    task automatic step();
        logic [31:0] code, tgt;
        @(negedge clk);
        code = ref_code();
        tgt  = (code == 32'he) ? eff_epc() : 32'h20;
        check("exc1",   exc1,   (rem1 > 0) ? 32'd0 : code);
        check("exc3",   exc3,   (rem3 > 0) ? 32'd0 : code);
        check("flush1", {31'd0, flush1}, {31'd0, rem1 > 0});
        check("flush3", {31'd0, flush3}, {31'd0, rem3 > 0});
        check("busy1",  {31'd0, busy1},  {31'd0, rem1 > 0});
        check("busy3",  {31'd0, busy3},  {31'd0, rem3 > 0});
        check("npc1",   npc1, mpc1);
        check("npc3",   npc3, mpc3);
        check("cia",    cia3, mem_pc);
        check("ds",     {31'd0, ds1}, {31'd0, mem_ds});
        @(posedge clk);
        if (rem1 > 0) rem1--;
        else if (code != 0) begin rem1 = 1; mpc1 = tgt; end
        if (rem3 > 0) rem3--;
        else if (code != 0) begin rem3 = 3; mpc3 = tgt; end
        #1;
    endtask

    task automatic wait_idle();
        quiet();
        for (int i = 0; i < 20 && (rem1 > 0 || rem3 > 0); i++) step();
        check("idle_reached", {31'd0, rem1 > 0 || rem3 > 0}, 32'd0);
    endtask

    // Called 1 unit after a rising edge; asserts reset between edges.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check("ar_flush1", {31'd0, flush1}, 32'd0);
        check("ar_flush3", {31'd0, flush3}, 32'd0);
        check("ar_busy3",  {31'd0, busy3},  32'd0);
        check("ar_exc1",   exc1, 32'd0);
        check("ar_exc3",   exc3, 32'd0);
        rem1 = 0; rem3 = 0; mpc1 = 32'd0; mpc3 = 32'd0;
        @(posedge clk);
        #1;
        check("ar_npc3", npc3, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        rem1 = 0; rem3 = 0; mpc1 = 32'd0; mpc3 = 32'd0;

        // Reset with a syscall already presented, then release.
        mem_pc = 32'h100; exc_flags[8] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_exc",   exc1, 32'd0);
        check("rst_flush", {31'd0, flush1}, 32'd0);
        check("rst_busy",  {31'd0, busy1},  32'd0);
        check("rst_npc",   npc1, 32'd0);
        rst = 1'b0;
        #1;
        check("s1_exc", exc1, 32'h8);
        step();
        check("s1_flush", {31'd0, flush1}, 32'd1);
        check("s1_npc",   npc1, 32'h20);
        quiet();
        step();
        check("s1_drop",  {31'd0, flush1}, 32'd0);

        // Interrupt beats syscall; masked by Status.EXL it does not.
        wait_idle();
        mem_pc = 32'h180; status = 32'h1000_0401; cause = 32'h400; exc_flags[8] = 1'b1;
        #1;
        check("int_win", exc1, 32'h1);
        step();
        wait_idle();
        mem_pc = 32'h180; status = 32'h1000_0403; cause = 32'h400; exc_flags[8] = 1'b1;
        #1;
        check("int_exl", exc1, 32'h8);
        step();

        // eret redirect takes the forwarded EPC.
        wait_idle();
        mem_pc = 32'h1c0; exc_flags[12] = 1'b1; epc = 32'h200;
        wb_we = 1'b1; wb_waddr = 5'd14; wb_data = 32'h300;
        step();
        check("eret_npc1", npc1, 32'h300);
        check("eret_npc3", npc3, 32'h300);

        // Three-cycle flush ignores an overflow arriving mid-flush.
        wait_idle();
        mem_pc = 32'h140; exc_flags[10] = 1'b1;
        step();
        quiet();
        step();
        mem_pc = 32'h144; exc_flags[11] = 1'b1;
        #1;
        check("ov_ignored", exc3, 32'd0);
        step();
        quiet();
        check("f3_cycle3", {31'd0, flush3}, 32'd1);
        step();
        check("f3_done",   {31'd0, flush3}, 32'd0);
        check("f3_noentry", {31'd0, busy3}, 32'd0);

        // Asynchronous reset in the middle of a flush.
        wait_idle();
        mem_pc = 32'h148; exc_flags[10] = 1'b1;
        step();
        quiet();
        async_reset();

        // Invalid PC suppresses exceptions; valid PC with delay slot flag.
        wait_idle();
        exc_flags[9] = 1'b1; mem_ds = 1'b1;
        #1;
        check("pc0_exc", exc1, 32'd0);
        step();
        check("pc0_noflush", {31'd0, flush1}, 32'd0);
        mem_pc = 32'h104;
        #1;
        check("ri_exc", exc1, 32'ha);
        check("ri_ds",  {31'd0, ds1}, 32'd1);
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            quiet();
            mem_pc    = ($urandom_range(0, 7) == 0) ? 32'd0 : {$urandom_range(1, 32'hffff), 2'b00};
            mem_ds    = 1'($urandom_range(0, 1));
            for (int b = 8; b <= 12; b++)
                exc_flags[b] = ($urandom_range(0, 5) == 0);
            status    = $urandom;
            if ($urandom_range(0, 1) == 1) begin status[1] = 1'b0; status[0] = 1'b1; end
            cause     = $urandom & 32'h0000_ff00;
            if ($urandom_range(0, 2) != 0) cause[15:8] = 8'd0;
            epc       = $urandom;
            wb_we     = 1'($urandom_range(0, 1));
            wb_waddr  = 5'($urandom_range(11, 15));
            wb_data   = $urandom;
            step();
            if (rem3 > 0 && $urandom_range(0, 39) == 0) async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
